flappy_game_ctrl: RTL

Game sequencer for the Flappy Bird VGA peripheral. It derives a once-per-frame tick from vertical sync and runs the IDLE/PLAYING/DYING/GAME_OVER state machine. It gates the per-frame step strobes to the bird-physics and pipe-scroll datapaths, turns flap writes into a flap command, and keeps score and high score. It sits between the Avalon register file (flap writes), the pixel pipeline (collision flag, pipe-pass events) and the physics/pipe update logic.

---
 rtl/flappy_game_if.sv | 24 ++
 rtl/flappy_game_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/flappy_game_if.sv
// flappy_game_if: sync/flap/collision inputs and frame strobes/score outputs of the game sequencer
interface flappy_game_if;
   logic       vga_vs;
   logic       flap_req;
   logic       collide;
   logic       pipe_passed;
   logic [1:0] state;
   logic       frame_tick;
   logic       phys_step;
   logic       pipe_step;
   logic       flap_go;
   logic       world_reset;
   logic [9:0] score;
   logic [9:0] high_score;
   logic       game_over;
   modport master (
      output vga_vs, flap_req, collide, pipe_passed,
      input  state, frame_tick, phys_step, pipe_step, flap_go, world_reset, score, high_score, game_over
   );
   modport slave (
      input  vga_vs, flap_req, collide, pipe_passed,
      output state, frame_tick, phys_step, pipe_step, flap_go, world_reset, score, high_score, game_over
   );
endinterface

// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl: per-frame game sequencer driving physics/pipe strobes, flap commands and scoring
module flappy_game_ctrl #(
   parameter int DEATH_FRAMES   = 60,
   parameter int HOLDOFF_FRAMES = 30,
   parameter int SCORE_MAX      = 999
) (
   input logic          clk,
   input logic          reset_n,
   flappy_game_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PLAYING, DYING, GAME_OVER} state_e;
   state_e     state_q, state_d;
   logic       vs_q, flap_q, flap_d, hit_q, hit_d;
   logic [7:0] death_q, death_d, hold_q, hold_d;
   logic [9:0] score_q, score_d, high_q, high_d;
   logic       tick, flap_ok, flap_now, hit_now;
   logic       phys, pipe, go, wr;
   // a flap is discarded outright while dying or during the game-over holdoff
   assign tick     = bus.vga_vs & ~vs_q;
   assign flap_ok  = (state_q != DYING) && !(state_q == GAME_OVER && hold_q != 8'd0);
   assign flap_now = flap_q | (bus.flap_req & flap_ok);
   assign hit_now  = hit_q | (bus.collide & (state_q == PLAYING));
   assign bus.state       = state_q;
   assign bus.frame_tick  = tick;
   assign bus.phys_step   = phys;
   assign bus.pipe_step   = pipe;
   assign bus.flap_go     = go;
   assign bus.world_reset = wr;
   assign bus.score       = score_q;
   assign bus.high_score  = high_q;
   assign bus.game_over   = state_q == GAME_OVER;
   // state register; vs_q resets high so no tick appears right after reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         vs_q    <= 1'b1;
         flap_q  <= 1'b0;
         hit_q   <= 1'b0;
         death_q <= '0;
         hold_q  <= '0;
         score_q <= '0;
         high_q  <= '0;
      end else begin
         state_q <= state_d;
         vs_q    <= bus.vga_vs;
         flap_q  <= flap_d;
         hit_q   <= hit_d;
         death_q <= death_d;
         hold_q  <= hold_d;
         score_q <= score_d;
         high_q  <= high_d;
      end
   end
   // next-state and per-frame strobes; strobes only ever assert in the tick cycle
   always_comb begin
      state_d = state_q;
      flap_d  = tick ? 1'b0 : flap_now;
      hit_d   = tick ? 1'b0 : hit_now;
      death_d = death_q;
      hold_d  = hold_q;
      score_d = score_q;
      high_d  = high_q;
      phys    = 1'b0;
      pipe    = 1'b0;
      go      = 1'b0;
      wr      = 1'b0;
      if (state_q == PLAYING && bus.pipe_passed && score_q != 10'(SCORE_MAX))
         score_d = score_q + 10'd1;
      if (tick) begin
         case (state_q)
            IDLE: if (flap_now) begin
               wr      = 1'b1;
               score_d = '0;
               state_d = PLAYING;
            end
            PLAYING: begin
               phys = 1'b1;
               if (hit_now) begin
                  death_d = 8'(DEATH_FRAMES - 1);
                  state_d = DYING;
               end else begin
                  pipe = 1'b1;
                  go   = flap_now;
               end
            end
            DYING: begin
               phys = 1'b1;
               if (death_q == 8'd0) begin
                  state_d = GAME_OVER;
                  hold_d  = 8'(HOLDOFF_FRAMES);
                  high_d  = (score_q > high_q) ? score_q : high_q;
               end else begin
                  death_d = death_q - 8'd1;
               end
            end
            GAME_OVER: begin
               if (hold_q != 8'd0) begin
                  hold_d = hold_q - 8'd1;
               end else if (flap_now) begin
                  wr      = 1'b1;
                  score_d = '0;
                  state_d = PLAYING;
               end
            end
         endcase
      end
   end
endmodule
